// File: rtl/oam_dma_engine_pkg.sv
// Shared constants and types for the OAM DMA engine.
// Also holds the echo-RAM page remap used when a start request is latched.
package oam_dma_engine_pkg;

   localparam logic [15:0] OAM_DMA_REG_ADDR = 16'hFF46;
   localparam int          OAM_DMA_LEN      = 160;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      XFER,
      DRAIN
   } dma_state_t;

   // Pages E0..FF alias the work RAM at C0..DF (echo region).
   function automatic logic [7:0] remap_page(input logic [7:0] page);
      return (page >= 8'hE0) ? (page & 8'hDF) : page;
   endfunction

endpackage

// File: rtl/oam_dma_engine_if.sv
// Start/bus signal bundle between the OAM DMA engine and its surroundings
// (register bank, memory unit read port, OAM write port, bus arbiter).
interface oam_dma_engine_if;

   logic        dma_start;
   logic [7:0]  dma_page;
   logic [15:0] mem_addr;
   logic        mem_oe;
   logic [7:0]  mem_rdata;
   logic [7:0]  oam_addr;
   logic        oam_we;
   logic [7:0]  oam_wdata;
   logic        dma_busy;
   logic        dma_done;

   modport slave (
      input  dma_start, dma_page, mem_rdata,
      output mem_addr, mem_oe, oam_addr, oam_we, oam_wdata, dma_busy, dma_done
   );

   modport master (
      output dma_start, dma_page, mem_rdata,
      input  mem_addr, mem_oe, oam_addr, oam_we, oam_wdata, dma_busy, dma_done
   );

endinterface

// File: rtl/oam_dma_engine_counter.sv
// 8-bit index counter with synchronous clear, count enable and a
// terminal-count flag raised while the count equals `last`.
module oam_dma_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] last,
   output logic [7:0] count,
   output logic       tc
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign tc    = (count_q == last);

endmodule

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies LENGTH bytes from {page,8'h00} into OAM offsets
// 0..LENGTH-1, one read per cycle, with each write landing one cycle later.
module oam_dma_engine
   import oam_dma_engine_pkg::*;
#(
   parameter int LENGTH      = OAM_DMA_LEN,
   parameter int START_DELAY = 1
) (
   input  logic            clk,
   input  logic            rst,
   oam_dma_engine_if.slave bus
);

   localparam logic [7:0]    IDX_LAST   = 8'(LENGTH - 1);
   localparam int            DW         = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
   localparam logic [DW-1:0] DELAY_LAST = (START_DELAY > 0) ? DW'(START_DELAY - 1) : '0;
   localparam int            RD         = 0;
   localparam int            WR         = 1;

   dma_state_t    state_q, state_d;
   logic [7:0]    page_q, page_d;
   logic [7:0]    oam_addr_q, oam_addr_d;
   logic [7:0]    oam_wdata_q, oam_wdata_d;
   logic [DW-1:0] delay_q, delay_d;
   logic          rd_pend_q, rd_pend_d;
   logic          mem_oe_c;
   logic          done_c;

   logic [1:0]    idx_clr;
   logic [1:0]    idx_en;
   logic [1:0]    idx_tc;
   logic [7:0]    idx [2];

   // Index 0 walks the read side, index 1 trails it by one cycle on the write side.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_idx
         oam_dma_counter u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (idx_clr[gi]),
            .en    (idx_en[gi]),
            .last  (IDX_LAST),
            .count (idx[gi]),
            .tc    (idx_tc[gi])
         );
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      page_d      = page_q;
      delay_d     = delay_q;
      rd_pend_d   = 1'b0;
      idx_clr     = '0;
      idx_en      = '0;
      mem_oe_c    = 1'b0;
      done_c      = 1'b0;

      // A read issued last cycle always retires, even in a restart cycle.
      idx_en[WR]  = rd_pend_q;
      oam_addr_d  = rd_pend_q ? idx[WR] : oam_addr_q;
      oam_wdata_d = rd_pend_q ? bus.mem_rdata : oam_wdata_q;

      case (state_q)
         IDLE: begin
         end
         WAIT: begin
            delay_d = delay_q + DW'(1);
            if (delay_q == DELAY_LAST) begin
               delay_d = '0;
               state_d = XFER;
            end
         end
         XFER: begin
            mem_oe_c   = 1'b1;
            idx_en[RD] = 1'b1;
            rd_pend_d  = 1'b1;
            if (idx_tc[RD]) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            done_c  = idx_tc[WR];
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Start (or restart) discards the read of this cycle and begins afresh.
      if (bus.dma_start) begin
         page_d     = remap_page(bus.dma_page);
         idx_clr    = 2'b11;
         delay_d    = '0;
         rd_pend_d  = 1'b0;
         state_d    = (START_DELAY == 0) ? XFER : WAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         page_q      <= '0;
         oam_addr_q  <= '0;
         oam_wdata_q <= '0;
         delay_q     <= '0;
         rd_pend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         page_q      <= page_d;
         oam_addr_q  <= oam_addr_d;
         oam_wdata_q <= oam_wdata_d;
         delay_q     <= delay_d;
         rd_pend_q   <= rd_pend_d;
      end
   end

   // Strobes are masked by rst so a reset cycle cannot commit a write.
   assign bus.mem_addr  = {page_q, idx[RD]};
   assign bus.mem_oe    = mem_oe_c & ~rst;
   assign bus.oam_we    = rd_pend_q & ~rst;
   assign bus.oam_addr  = oam_addr_d;
   assign bus.oam_wdata = oam_wdata_d;
   assign bus.dma_busy  = (state_q != IDLE);
   assign bus.dma_done  = done_c & ~rst;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: a 160-byte/delay-1 instance and a 256-byte/delay-0
// instance, driven with random memory and pages, checked against transfer rules.
module tb_oam_dma_engine;
   import oam_dma_engine_pkg::*;

   localparam int LEN_A = OAM_DMA_LEN;
   localparam int LEN_B = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   oam_dma_engine_if bus_a ();
   oam_dma_engine_if bus_b ();

   oam_dma_engine #(.LENGTH(LEN_A), .START_DELAY(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   oam_dma_engine #(.LENGTH(LEN_B), .START_DELAY(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   logic [7:0]  src_mem [65536];
   logic [7:0]  oam_a [256];
   logic [7:0]  oam_b [256];
   logic [7:0]  oam_pre [256];
   int          cyc = 0;
   int          busy_a = 0, done_a = 0, last_we_a = 0;
   int          busy_b = 0, done_b = 0, wr_b = 0, ff_b = 0;
   logic [15:0] addr_a [$];
   logic [15:0] addr_b [$];
   int          oe_cyc_a [$];
   int          oe_cyc_b [$];
   int          vectors = 0;
   int          miscompares = 0;

   // Memory unit (one-cycle read latency) and OAM storage.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      bus_a.mem_rdata <= bus_a.mem_oe ? src_mem[bus_a.mem_addr] : 8'($urandom);
      bus_b.mem_rdata <= bus_b.mem_oe ? src_mem[bus_b.mem_addr] : 8'($urandom);
      if (bus_a.oam_we) oam_a[bus_a.oam_addr] <= bus_a.oam_wdata;
      if (bus_b.oam_we) oam_b[bus_b.oam_addr] <= bus_b.oam_wdata;
   end

   always @(negedge clk) begin
      if (bus_a.dma_busy) busy_a++;
      if (bus_a.dma_done) done_a++;
      if (bus_a.mem_oe) begin
         addr_a.push_back(bus_a.mem_addr);
         oe_cyc_a.push_back(cyc);
      end
      if (bus_a.oam_we) last_we_a = cyc;
      if (bus_b.dma_busy) busy_b++;
      if (bus_b.dma_done) done_b++;
      if (bus_b.mem_oe) begin
         addr_b.push_back(bus_b.mem_addr);
         oe_cyc_b.push_back(cyc);
      end
      if (bus_b.oam_we) begin
         wr_b++;
         if (bus_b.oam_addr == 8'hFF) ff_b++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Echo region E0..FF mirrors C0..DF.
   function automatic logic [7:0] eff_page(input logic [7:0] p);
      return (p >= 8'hE0) ? p - 8'h20 : p;
   endfunction

   task automatic start_a(input logic [7:0] page, output int s);
      bus_a.dma_page  = page;
      bus_a.dma_start = 1'b1;
      s = cyc;
      step(1);
      bus_a.dma_start = 1'b0;
      bus_a.dma_page  = 8'($urandom);
   endtask

   task automatic wait_done(input bit sel_b, input int target, input int budget);
      int k;
      k = 0;
      while (((sel_b ? done_b : done_a) < target) && (k < budget)) begin
         step(1);
         k++;
      end
      check(sel_b ? "done_b_reached" : "done_a_reached",
            32'((sel_b ? done_b : done_a) >= target), 32'd1);
   endtask

   task automatic check_oam_a(input string tag, input logic [7:0] pe, input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         check({tag, "_oam"}, oam_a[i], src_mem[{pe, 8'(i)}]);
   endtask

   task automatic check_pre_a(input string tag, input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         check({tag, "_keep"}, oam_a[i], oam_pre[i]);
   endtask

   task automatic snap_a();
      for (int i = 0; i < 256; i++) oam_pre[i] = oam_a[i];
   endtask

   task automatic check_seq_a(input string tag, input int base, input logic [7:0] pe);
      check({tag, "_nrd"}, 32'(addr_a.size() - base), 32'(LEN_A));
      for (int i = 0; i < LEN_A; i++)
         check({tag, "_addr"}, addr_a[base + i], {pe, 8'(i)});
   endtask

   task automatic run_a(input string tag, input logic [7:0] page);
      int s, b_busy, b_done, b_addr;
      logic [7:0] pe;
      pe     = eff_page(page);
      b_busy = busy_a;
      b_done = done_a;
      b_addr = addr_a.size();
      start_a(page, s);
      wait_done(1'b0, b_done + 1, 400);
      step(3);
      check({tag, "_busy"}, 32'(busy_a - b_busy), 32'(LEN_A + 2));
      check({tag, "_done"}, 32'(done_a - b_done), 32'd1);
      check({tag, "_first_rd"}, 32'(oe_cyc_a[b_addr] - s), 32'd2);
      check({tag, "_last_wr"}, 32'(last_we_a - s), 32'(2 + LEN_A));
      check_seq_a(tag, b_addr, pe);
      check_oam_a(tag, pe, 0, LEN_A - 1);
   endtask

   initial begin
      int s, s2, b_busy, b_done, b_addr;
      logic [7:0] p1, p2;

      bus_a.dma_start = 1'b0;
      bus_a.dma_page  = 8'h00;
      bus_b.dma_start = 1'b0;
      bus_b.dma_page  = 8'h00;
      for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
      for (int i = 0; i < LEN_A; i++) src_mem[16'hC100 + i] = 8'(i) ^ 8'h5A;

      // Reset, with a start request colliding with the last reset cycle.
      step(2);
      bus_a.dma_start = 1'b1;
      bus_a.dma_page  = 8'hC1;
      step(1);
      bus_a.dma_start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mem_addr", bus_a.mem_addr, 16'h0000);
      check("rst_mem_oe", bus_a.mem_oe, 1'b0);
      check("rst_oam_addr", bus_a.oam_addr, 8'h00);
      check("rst_oam_we", bus_a.oam_we, 1'b0);
      check("rst_oam_wdata", bus_a.oam_wdata, 8'h00);
      check("rst_busy", bus_a.dma_busy, 1'b0);
      check("rst_done", bus_a.dma_done, 1'b0);
      check("rst_b_busy", bus_b.dma_busy, 1'b0);
      @(posedge clk);
      #1;

      // Plain transfer from C1 with the xor pattern, then echo page FE.
      run_a("t1", 8'hC1);
      for (int i = 0; i < LEN_A; i++)
         check("t1_pattern", oam_a[i], 8'(i) ^ 8'h5A);
      step(2);
      b_addr = addr_a.size();
      run_a("t2", 8'hFE);
      check("t2_first", addr_a[b_addr], 16'hDE00);
      check("t2_last", addr_a[b_addr + LEN_A - 1], 16'hDE9F);

      for (int r = 0; r < 3; r++) begin
         step(1 + $urandom_range(0, 3));
         run_a("rnd", 8'($urandom));
      end

      // Restart in the cycle write #49 retires.
      step(2);
      snap_a();
      b_busy = busy_a;
      b_done = done_a;
      start_a(8'hC0, s);
      step(51);
      start_a(8'h80, s2);
      check("t3_gap", 32'(s2 - s), 32'd52);
      check_oam_a("t3_part", 8'hC0, 0, 49);
      check_pre_a("t3_part", 50, LEN_A - 1);
      check("t3_nodone", 32'(done_a - b_done), 32'd0);
      wait_done(1'b0, b_done + 1, 400);
      step(3);
      check("t3_busy", 32'(busy_a - b_busy), 32'(52 + LEN_A + 2));
      check("t3_done", 32'(done_a - b_done), 32'd1);
      check_seq_a("t3", addr_a.size() - LEN_A, 8'h80);
      check_oam_a("t3_final", 8'h80, 0, LEN_A - 1);

      // Reset in the cycle write #20 would retire.
      step(2);
      snap_a();
      b_done = done_a;
      p1 = 8'($urandom_range(0, 8'hDF));
      start_a(p1, s);
      step(22);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      @(negedge clk);
      check("t4_mem_addr", bus_a.mem_addr, 16'h0000);
      check("t4_mem_oe", bus_a.mem_oe, 1'b0);
      check("t4_oam_addr", bus_a.oam_addr, 8'h00);
      check("t4_oam_we", bus_a.oam_we, 1'b0);
      check("t4_oam_wdata", bus_a.oam_wdata, 8'h00);
      check("t4_busy", bus_a.dma_busy, 1'b0);
      check("t4_done", bus_a.dma_done, 1'b0);
      @(posedge clk);
      #1;
      step(5);
      check("t4_nodone", 32'(done_a - b_done), 32'd0);
      check_oam_a("t4", p1, 0, 19);
      check_pre_a("t4", 20, LEN_A - 1);

      // Back-to-back: second start lands in the dma_done cycle.
      step(2);
      b_busy = busy_a;
      b_done = done_a;
      p1 = 8'($urandom);
      p2 = 8'($urandom);
      start_a(p1, s);
      step(161);
      start_a(p2, s2);
      check("t5_done1", 32'(done_a - b_done), 32'd1);
      check_oam_a("t5_first", eff_page(p1), 0, LEN_A - 1);
      wait_done(1'b0, b_done + 2, 400);
      step(3);
      check("t5_busy", 32'(busy_a - b_busy), 32'(2 * (LEN_A + 2)));
      check("t5_done", 32'(done_a - b_done), 32'd2);
      check_oam_a("t5_second", eff_page(p2), 0, LEN_A - 1);

      // Full-page transfer on the 256-byte, zero-delay instance.
      b_busy = busy_b;
      b_addr = addr_b.size();
      bus_b.dma_page  = 8'h00;
      bus_b.dma_start = 1'b1;
      s = cyc;
      step(1);
      bus_b.dma_start = 1'b0;
      wait_done(1'b1, 1, 600);
      step(3);
      check("t6_busy", 32'(busy_b - b_busy), 32'(LEN_B + 1));
      check("t6_done", 32'(done_b), 32'd1);
      check("t6_writes", 32'(wr_b), 32'(LEN_B));
      check("t6_ff_once", 32'(ff_b), 32'd1);
      check("t6_first_rd", 32'(oe_cyc_b[b_addr] - s), 32'd1);
      check("t6_nrd", 32'(addr_b.size() - b_addr), 32'(LEN_B));
      for (int i = 0; i < LEN_B; i++) begin
         check("t6_addr", addr_b[b_addr + i], 16'(i));
         check("t6_oam", oam_b[i], src_mem[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
